// File: rtl/text_msg_pkg.sv
// Shared types and message tables for the end-of-game text overlay.
package text_msg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TYPE = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [6:0]   SPACE         = 7'h20;
   localparam logic [127:0] MSG_GAME_OVER = "GAME OVER       ";
   localparam logic [127:0] MSG_YOU_WIN   = "YOU WIN         ";

   // Entry [sel][15-idx] holds character idx; string literals place char 0 in the top byte.
   localparam logic [1:0][15:0][7:0] MSG_ROM = {MSG_YOU_WIN, MSG_GAME_OVER};
   localparam logic [1:0][4:0]       MSG_LEN = {5'd7, 5'd9};

   function automatic logic [6:0] msg_char(input logic sel, input logic [3:0] idx);
      logic [7:0] byte_v;
      byte_v = MSG_ROM[sel][4'd15 - idx];
      return byte_v[6:0];
   endfunction

endpackage

// File: rtl/text_msg_ctrl_frame_divider.sv
// Tick-qualified modulo-N counter with synchronous clear; o_wrap pulses on the
// tick that takes the count from N-1 back to 0.
module frame_divider #(
   parameter int N = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_tick,
   output logic o_wrap
);

   localparam int W = (N > 1) ? $clog2(N) : 1;
   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] r_cnt;

   always_comb begin
      o_wrap = i_tick & ~i_clr & (r_cnt == LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_tick) begin
         r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/text_msg_ctrl.sv
// End-of-game overlay sequencer: typewriter reveal of GAME OVER / YOU WIN, then
// blinking hold, plus a 1-cycle char_xy -> ASCII lookup for the font ROM.
module text_msg_ctrl
   import text_msg_pkg::*;
#(
   parameter logic [3:0] MSG_ROW      = 4'd7,
   parameter logic [3:0] MSG_COL      = 4'd3,
   parameter int         CHAR_FRAMES  = 8,
   parameter int         BLINK_FRAMES = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       endgame,
   input  logic       win,
   input  logic       frame_tick,
   input  logic [7:0] char_xy,
   output logic [6:0] char_code,
   output logic       text_en,
   output logic       done
);

   if ((int'(MSG_COL) + int'(MSG_LEN[0]) > 16) || (int'(MSG_COL) + int'(MSG_LEN[1]) > 16) ||
       (CHAR_FRAMES < 1) || (BLINK_FRAMES < 1)) begin : g_bad_params
      $error("text_msg_ctrl: message does not fit the text row or frame counts < 1");
   end

   state_t     r_state, w_state_nxt;
   logic [4:0] r_revealed, w_revealed_nxt;
   logic       r_visible, w_visible_nxt;
   logic       r_msg_sel, w_msg_sel_nxt;
   logic       r_endgame_d;
   logic       r_text_en, r_done;
   logic [6:0] r_char_code, w_char_code_nxt;
   logic       w_rise, w_char_wrap, w_blink_wrap;
   logic       w_char_clr, w_blink_clr;
   logic [3:0] w_row, w_col, w_idx;

   always_comb begin
      w_rise      = endgame & ~r_endgame_d;
      // Clearing while endgame is low keeps the abort path free of stray wraps.
      w_char_clr  = (r_state != TYPE) | ~endgame;
      w_blink_clr = (r_state != HOLD) | ~endgame;
   end

   frame_divider #(.N(CHAR_FRAMES)) u_char_div (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_char_clr),
      .i_tick (frame_tick),
      .o_wrap (w_char_wrap)
   );

   frame_divider #(.N(BLINK_FRAMES)) u_blink_div (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_blink_clr),
      .i_tick (frame_tick),
      .o_wrap (w_blink_wrap)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_revealed_nxt = r_revealed;
      w_visible_nxt  = r_visible;
      w_msg_sel_nxt  = r_msg_sel;
      case (r_state)
         IDLE: begin
            w_revealed_nxt = 5'd0;
            w_visible_nxt  = 1'b1;
            if (w_rise) begin
               w_state_nxt   = TYPE;
               w_msg_sel_nxt = win;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         TYPE: begin
            if (!endgame) begin
               w_state_nxt    = IDLE;
               w_revealed_nxt = 5'd0;
            end else if (w_char_wrap) begin
               w_revealed_nxt = r_revealed + 5'd1;
               if (w_revealed_nxt == MSG_LEN[r_msg_sel]) begin
                  w_state_nxt   = HOLD;
                  w_visible_nxt = 1'b1;
               end else begin
                  w_state_nxt = TYPE;
               end
            end else begin
               w_state_nxt = TYPE;
            end
         end
         HOLD: begin
            if (!endgame) begin
               w_state_nxt    = IDLE;
               w_revealed_nxt = 5'd0;
            end else if (w_blink_wrap) begin
               w_visible_nxt = ~r_visible;
            end else begin
               w_state_nxt = HOLD;
            end
         end
         default: begin
            w_state_nxt    = IDLE;
            w_revealed_nxt = 5'd0;
            w_visible_nxt  = 1'b1;
         end
      endcase
   end

   always_comb begin
      w_row = char_xy[7:4];
      w_col = char_xy[3:0];
      w_idx = w_col - MSG_COL;
      if ((w_row == MSG_ROW) && (w_col >= MSG_COL) && ({1'b0, w_idx} < r_revealed) &&
          (r_state != IDLE)) begin
         w_char_code_nxt = msg_char(r_msg_sel, w_idx);
      end else begin
         w_char_code_nxt = SPACE;
      end
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_revealed  <= 5'd0;
         r_visible   <= 1'b1;
         r_msg_sel   <= 1'b0;
         r_endgame_d <= 1'b0;
         r_text_en   <= 1'b0;
         r_done      <= 1'b0;
         r_char_code <= SPACE;
      end else begin
         r_state     <= w_state_nxt;
         r_revealed  <= w_revealed_nxt;
         r_visible   <= w_visible_nxt;
         r_msg_sel   <= w_msg_sel_nxt;
         r_endgame_d <= endgame;
         r_text_en   <= (w_state_nxt == TYPE) | ((w_state_nxt == HOLD) & w_visible_nxt);
         r_done      <= (w_state_nxt == HOLD);
         r_char_code <= w_char_code_nxt;
      end
   end

   assign char_code = r_char_code;
   assign text_en   = r_text_en;
   assign done      = r_done;

endmodule

// File: tb/tb_text_msg_ctrl.sv
// Directed bench for text_msg_ctrl with CHAR_FRAMES=2, BLINK_FRAMES=3.
module tb_text_msg_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       endgame = 1'b0;
   logic       win = 1'b0;
   logic       frame_tick = 1'b0;
   logic [7:0] char_xy = 8'h00;
   logic [6:0] char_code;
   logic       text_en;
   logic       done;

   int checks = 0;
   int errors = 0;
   logic [6:0] exp_q[$];

   text_msg_ctrl #(
      .MSG_ROW(4'd7), .MSG_COL(4'd3), .CHAR_FRAMES(2), .BLINK_FRAMES(3)
   ) dut (
      .clk(clk), .rst(rst), .endgame(endgame), .win(win), .frame_tick(frame_tick),
      .char_xy(char_xy), .char_code(char_code), .text_en(text_en), .done(done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic lookup(input string tag, input logic [7:0] xy, input logic [6:0] exp);
      logic [6:0] e;
      char_xy = xy;
      exp_q.push_back(exp);
      step();
      e = exp_q.pop_front();
      chk(tag, {1'b0, char_code}, {1'b0, e});
   endtask

   task automatic chk_flags(input string tag, input logic en, input logic dn);
      chk({tag, "_en"}, {7'd0, text_en}, {7'd0, en});
      chk({tag, "_done"}, {7'd0, done}, {7'd0, dn});
   endtask

   initial begin
      // 1. reset held while inputs toggle
      for (int i = 0; i < 6; i++) begin
         endgame    = i[0];
         win        = i[1];
         frame_tick = ~i[0];
         char_xy    = 8'($urandom);
         step();
         chk("rst_code", {1'b0, char_code}, 8'h20);
         chk_flags("rst", 1'b0, 1'b0);
      end
      endgame = 1'b0; frame_tick = 1'b0; win = 1'b0;
      step();
      rst = 1'b0;
      step();
      ticks(10);
      chk_flags("idle", 1'b0, 1'b0);
      lookup("idle_code", 8'h73, 7'h20);

      // 2. GAME OVER reveal
      win = 1'b0; endgame = 1'b1;
      step();
      chk_flags("type_start", 1'b1, 1'b0);
      ticks(2);
      lookup("go_G", 8'h73, 7'h47);
      lookup("go_next_blank", 8'h74, 7'h20);
      ticks(15);
      chk_flags("go_17", 1'b1, 1'b0);
      lookup("go_R_hidden", 8'h7B, 7'h20);
      tick();
      chk_flags("go_hold", 1'b1, 1'b1);
      lookup("go_R", 8'h7B, 7'h52);
      lookup("go_past_end", 8'h7C, 7'h20);

      // 4. blink in HOLD
      for (int t = 1; t <= 9; t++) begin
         tick();
         chk_flags($sformatf("blink_%0d", t), ((t / 3) % 2) == 0, 1'b1);
      end

      // 3. YOU WIN with win dropped mid-TYPE
      endgame = 1'b0;
      step();
      chk_flags("abort_hold", 1'b0, 1'b0);
      win = 1'b1; endgame = 1'b1;
      step();
      win = 1'b0;
      ticks(13);
      chk_flags("yw_13", 1'b1, 1'b0);
      tick();
      chk_flags("yw_hold", 1'b1, 1'b1);
      lookup("yw_N", 8'h79, 7'h4E);
      lookup("yw_Y", 8'h73, 7'h59);
      lookup("yw_past_end", 8'h7A, 7'h20);
      lookup("yw_off_row", 8'h63, 7'h20);
      lookup("yw_left_of_msg", 8'h72, 7'h20);

      // 5. abort mid-TYPE and restart
      endgame = 1'b0;
      step();
      endgame = 1'b1; win = 1'b0;
      step();
      ticks(8);
      lookup("ab_E", 8'h76, 7'h45);
      lookup("ab_hidden", 8'h77, 7'h20);
      endgame = 1'b0;
      char_xy = 8'h73;
      step();
      chk_flags("ab_idle", 1'b0, 1'b0);
      lookup("ab_idle_code", 8'h73, 7'h20);
      endgame = 1'b1;
      step();
      tick();
      lookup("rs_not_yet", 8'h73, 7'h20);
      tick();
      lookup("rs_G", 8'h73, 7'h47);

      // 6a. frame_tick coincident with the rise is ignored
      endgame = 1'b0;
      step();
      endgame = 1'b1; frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      tick();
      lookup("co_one_tick", 8'h73, 7'h20);
      tick();
      lookup("co_G", 8'h73, 7'h47);

      // 6b. async reset mid-HOLD
      ticks(16);
      chk_flags("pre_rst_hold", text_en, 1'b1);
      lookup("pre_rst_R", 8'h7B, 7'h52);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_code", {1'b0, char_code}, 8'h20);
      chk_flags("arst", 1'b0, 1'b0);
      endgame = 1'b0;
      step();
      rst = 1'b0;
      step();
      chk_flags("post_rst", 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/text_msg_ctrl.md
Name: text_msg_ctrl

Overview:
- Sequences the end-of-game text overlay drawn by draw_rect_char.
- On an endgame rising edge it latches which message to show (GAME OVER / YOU WIN) and reveals it one character at a time, paced by frames (typewriter effect); then holds it, blinking.
- Answers draw_rect_char's char_xy lookups with the ASCII code fed to the font ROM, with a fixed 1-cycle latency.

Parameters:
- MSG_ROW, 4'd7, text row (char_xy[7:4]) on which the message is placed.
- MSG_COL, 4'd3, first text column (char_xy[3:0]) of the message.
- CHAR_FRAMES, 8, frames between successive revealed characters (≥1).
- BLINK_FRAMES, 30, frames per blink half-period in HOLD (≥1).

Ports:
- clk  in  1  pixel clock (40 MHz).
- rst  in  1  asynchronous, active-high reset.
- endgame  in  1  level: game over while high.
- win  in  1  message select, sampled only on the endgame rising edge (1 = YOU WIN, 0 = GAME OVER).
- frame_tick  in  1  one-cycle pulse per frame (vsync start).
- char_xy  in  8  {row[3:0], col[3:0]} text cell currently being drawn.
- char_code  out  7  ASCII code for the font ROM, registered.
- text_en  out  1  overlay enable to draw_rect_char, registered.
- done  out  1  high while in HOLD (full message shown).

Behaviour:
- Reset (async, rst=1): state=IDLE, char_code=7'h20, text_en=0, done=0, revealed=0, frame_cnt=0, blink_cnt=0, visible=1, msg_sel=0, endgame_d=0.
- Edge detect: endgame_d registers endgame; rise = endgame & ~endgame_d.
- States:
  - IDLE: text_en=0, revealed=0. On rise → TYPE, latch msg_sel=win, clear frame_cnt.
  - TYPE: text_en=1. On frame_tick, frame_cnt++. When frame_cnt reaches CHAR_FRAMES-1 on a tick, it wraps to 0 and revealed++. When revealed becomes MSG_LEN[msg_sel] → HOLD, clear blink_cnt, set visible=1.
  - HOLD: text_en=visible, done=1. On frame_tick, blink_cnt++. When blink_cnt reaches BLINK_FRAMES-1 on a tick, it wraps to 0 and visible toggles.
- endgame low in TYPE or HOLD → IDLE on the next edge. This has priority over every other transition and tick. Re-assertion restarts from revealed=0.
- rise coincident with frame_tick: the tick is ignored (counters start cleared).
- Lookup, registered every cycle with 1-cycle latency regardless of state:
  - idx = col - MSG_COL, 4-bit.
  - char_code = MSG_ROM[msg_sel][idx] when row==MSG_ROW, col≥MSG_COL, idx<revealed and state≠IDLE.
  - Otherwise char_code = 7'h20 (space).
  - Columns beyond the message length always give a space, because revealed ≤ MSG_LEN.
- MSG_LEN is ≤ 16 and MSG_COL+MSG_LEN ≤ 16; no column wrap-around is permitted. An elaboration-time assertion enforces this.
- revealed is 5 bits, so a 16-character message is representable.
- Reset asserted mid-TYPE/HOLD → immediate return to reset values.
- A rise while already in TYPE/HOLD is impossible, since endgame must fall first.

Decomposition:
- Package text_msg_pkg holds:
  - state_t enum {IDLE, TYPE, HOLD}.
  - MSG_GAME_OVER = "GAME OVER", MSG_YOU_WIN = "YOU WIN", each padded with spaces to 16 chars.
  - MSG_ROM[2][16] as 7-bit codes.
  - MSG_LEN[2] = {9, 7}.
  - SPACE = 7'h20.
- One sub-module: frame_divider (tick-qualified modulo-N counter with clear, emitting a wrap pulse). It is instantiated twice: once for character pacing and once for blink.

Test Plan:
1. Reset: hold rst=1, toggle all inputs → char_code=7'h20, text_en=0, done=0 throughout. After release with endgame=0 and 10 frame_ticks → still IDLE and blank.
2. GAME OVER reveal (CHAR_FRAMES=2): endgame 0→1 with win=0, then 18 frame_ticks.
   - After 2 ticks, char_xy=8'h73 → char_code='G' (7'h47) one cycle later; char_xy=8'h74 → 7'h20.
   - After 18 ticks, done=1 and char_xy=8'h7B → 'R' (7'h52).
3. YOU WIN select and latching: endgame rise with win=1, then win→0 mid-TYPE → message stays YOU WIN.
   - After 14 ticks, done=1; char_xy=8'h79 → 'N' (7'h4E); char_xy=8'h7A → 7'h20.
   - Off-row lookup char_xy=8'h63 → 7'h20.
4. Blink (BLINK_FRAMES=3) in HOLD: text_en toggles after ticks 3, 6 and 9 (1→0→1→0), while done stays 1.
5. Abort and restart: drop endgame mid-TYPE (revealed=4) → next cycle IDLE, text_en=0, char_code=7'h20 for char_xy=8'h73. Re-raise endgame → reveal restarts with revealed=0.
6. Simultaneous events:
   - frame_tick coincident with the endgame rise → first character appears only after CHAR_FRAMES further ticks.
   - rst pulse mid-HOLD → all outputs return to reset values asynchronously, before the next clock edge.
